sec_b2a_serial: RTL and testbench



---
 rtl/sec_b2a_pkg.sv | 30 +++
 rtl/sec_digit_add.sv | 68 ++++++
 rtl/sec_b2a_serial.sv | 163 ++++++++++++++++
 tb/tb_sec_b2a_serial.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sec_b2a_pkg.sv
// Shared types and sizing helpers for the serial masked Boolean-to-arithmetic converter.
package sec_b2a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_REFRESH,
        ST_FOLD,
        ST_DONE
    } state_t;

    // Random bits consumed by one ISW AND over n shares.
    function automatic int and_rand(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Random bits consumed by one ADD step: two ISW ANDs per digit bit.
    function automatic int step_rand(input int n, input int digit);
        return digit * n * (n - 1);
    endfunction

    // Accept edge to o_valid rise, with randomness never stalled.
    function automatic int latency(input int n, input int k, input int digit);
        return (n - 1) * k / digit + 3;
    endfunction

    localparam int AND_RAND  = and_rand(3);
    localparam int STEP_RAND = step_rand(3, 1);

endpackage

// File: rtl/sec_digit_add.sv
// Combinational masked DIGIT-bit ripple-carry step over N_SHARES Boolean shares.
// Share i of every slice occupies bits [i*DIGIT +: DIGIT]; carry share i is bit i.
module sec_digit_add
    import sec_b2a_pkg::*;
#(
    parameter int N_SHARES = 3,
    parameter int DIGIT    = 1,
    localparam int AND_R   = and_rand(N_SHARES),
    localparam int STEP_R  = step_rand(N_SHARES, DIGIT)
) (
    input  logic [N_SHARES*DIGIT-1:0] s_slice,
    input  logic [N_SHARES*DIGIT-1:0] t_slice,
    input  logic [N_SHARES-1:0]       c_in,
    input  logic [STEP_R-1:0]         rnd,
    output logic [N_SHARES*DIGIT-1:0] sum_slice,
    output logic [N_SHARES-1:0]       c_out
);

    logic [N_SHARES-1:0] carry;
    logic [N_SHARES-1:0] s_bit;
    logic [N_SHARES-1:0] t_bit;
    logic [N_SHARES-1:0] st_bit;

    // ISW multiplication: each pair (i,j) shares one random bit, so the XOR of the
    // result shares equals (XOR of a) & (XOR of b) without ever recombining a or b.
    function automatic logic [N_SHARES-1:0] isw_and(
        input logic [N_SHARES-1:0] a,
        input logic [N_SHARES-1:0] b,
        input logic [AND_R-1:0]    r
    );
        logic [N_SHARES-1:0] z;
        int k;
        z = a & b;
        k = 0;
        for (int i = 0; i < N_SHARES; i++) begin
            for (int j = i + 1; j < N_SHARES; j++) begin
                z[i] = z[i] ^ r[k];
                z[j] = z[j] ^ r[k] ^ (a[i] & b[j]) ^ (a[j] & b[i]);
                k++;
            end
        end
        return z;
    endfunction

    // Ripple LSB-first: sum = s^t^c, carry = (s&t) ^ (c&(s^t)), two fresh AND randomness blocks per bit.
    always_comb begin
        // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
        carry     = c_in;
        sum_slice = '0;
        s_bit     = '0;
        t_bit     = '0;
        st_bit    = '0;
        for (int b = 0; b < DIGIT; b++) begin
            for (int i = 0; i < N_SHARES; i++) begin
                s_bit[i] = s_slice[i*DIGIT + b];
                t_bit[i] = t_slice[i*DIGIT + b];
            end
            st_bit = s_bit ^ t_bit;
            for (int i = 0; i < N_SHARES; i++) begin
                sum_slice[i*DIGIT + b] = st_bit[i] ^ carry[i];
            end
            carry = isw_and(s_bit, t_bit, rnd[(2*b)*AND_R +: AND_R])
                  ^ isw_and(carry, st_bit, rnd[(2*b+1)*AND_R +: AND_R]);
        end
        c_out = carry;
    end

endmodule

// File: rtl/sec_b2a_serial.sv
// Serial masked Boolean-to-arithmetic converter. Subtracts each random arithmetic
// share A_p from the Boolean-masked word with one time-multiplexed masked adder,
// then refreshes and folds the Boolean remainder into the last arithmetic share.
module sec_b2a_serial
    import sec_b2a_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 3,
    parameter int DIGIT    = 1,
    parameter int RAND_W   = K_WIDTH * (N_SHARES - 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [K_WIDTH*N_SHARES-1:0]   i_b,
    input  logic                          i_rvld,
    input  logic [RAND_W-1:0]             i_n,
    output logic                          o_rreq,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [K_WIDTH*N_SHARES-1:0]   o_a
);

    localparam int N      = N_SHARES;
    localparam int K      = K_WIDTH;
    localparam int ND     = K / DIGIT;
    localparam int STEP_R = step_rand(N, DIGIT);
    localparam int PW     = $clog2(N);
    localparam int DW     = $clog2(ND);

    state_t              state;
    logic [K*N-1:0]      s_q;
    logic [K*(N-1)-1:0]  a_q;
    logic [N-1:0]        c_q;
    logic [PW-1:0]       p_q;
    logic [DW-1:0]       d_q;

    logic [K-1:0]        t_word;
    logic [N*DIGIT-1:0]  s_slice;
    logic [N*DIGIT-1:0]  t_slice;
    logic [N*DIGIT-1:0]  sum_slice;
    logic [N-1:0]        c_next;
    logic [K*N-1:0]      s_add;
    logic [K*N-1:0]      s_ref;
    logic [K-1:0]        r_acc;
    logic [K-1:0]        fold_acc;

    assign o_ready = (state == ST_IDLE);
    assign o_rreq  = (state == ST_IDLE) || (state == ST_ADD) || (state == ST_REFRESH);

    // Select the current digit of every S share and of the trivially shared operand -A_p.
    always_comb begin
        t_word  = -a_q[p_q*K +: K];
        s_slice = '0;
        t_slice = '0;
        for (int i = 0; i < N; i++) begin
            s_slice[i*DIGIT +: DIGIT] = s_q[i*K + d_q*DIGIT +: DIGIT];
        end
        t_slice[0 +: DIGIT] = t_word[d_q*DIGIT +: DIGIT];
    end

    sec_digit_add #(
        .N_SHARES (N),
        .DIGIT    (DIGIT)
    ) u_digit_add (
        .s_slice   (s_slice),
        .t_slice   (t_slice),
        .c_in      (c_q),
        .rnd       (i_n[STEP_R-1:0]),
        .sum_slice (sum_slice),
        .c_out     (c_next)
    );

    // Next S after an ADD step (digit written back in place) and after a REFRESH.
    always_comb begin
        s_add = s_q;
        for (int i = 0; i < N; i++) begin
            s_add[i*K + d_q*DIGIT +: DIGIT] = sum_slice[i*DIGIT +: DIGIT];
        end
        s_ref = s_q;
        r_acc = '0;
        for (int i = 0; i < N - 1; i++) begin
            s_ref[i*K +: K] = s_q[i*K +: K] ^ i_n[i*K +: K];
            r_acc           = r_acc ^ i_n[i*K +: K];
        end
        s_ref[(N-1)*K +: K] = s_q[(N-1)*K +: K] ^ r_acc;
    end

    // Recombine the Boolean remainder for the last arithmetic share.
    always_comb begin
        fold_acc = '0;
        for (int i = 0; i < N; i++) begin
            fold_acc = fold_acc ^ s_q[i*K +: K];
        end
    end

    // Control FSM and datapath registers; ADD and REFRESH hold everything while i_rvld is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: share registers are cleared too, so an aborted job leaves no share material behind.
            state   <= ST_IDLE;
            s_q     <= '0;
            a_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            d_q     <= '0;
            o_valid <= 1'b0;
            o_a     <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every read sees the pre-edge value.
            case (state)
                ST_IDLE: begin
                    if (i_valid && i_rvld) begin
                        s_q   <= i_b;
                        a_q   <= i_n[K*(N-1)-1:0];
                        c_q   <= '0;
                        p_q   <= '0;
                        d_q   <= '0;
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (i_rvld) begin
                        s_q <= s_add;
                        if (d_q == DW'(ND - 1)) begin
                            // Carry out of the MSB is dropped: arithmetic is mod 2^K.
                            d_q <= '0;
                            c_q <= '0;
                            p_q <= p_q + 1'b1;
                            if (p_q == PW'(N - 2)) begin
                                state <= ST_REFRESH;
                            end
                        end else begin
                            d_q <= d_q + 1'b1;
                            c_q <= c_next;
                        end
                    end
                end
                ST_REFRESH: begin
                    if (i_rvld) begin
                        s_q   <= s_ref;
                        state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    o_a   <= {fold_acc, a_q};
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sec_b2a_serial.sv
// Directed self-checking bench for sec_b2a_serial (N=3/K=32/DIGIT=1 and N=4/K=32/DIGIT=4).
module tb_sec_b2a_serial;

    localparam int K  = 32;
    localparam int N  = 3;
    localparam int RW = K * (N - 1);

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            rst_i;
    logic            i_valid, i_rvld, i_ready;
    logic [K*N-1:0]  i_b;
    logic [RW-1:0]   i_n;
    logic            o_ready, o_rreq, o_valid;
    logic [K*N-1:0]  o_a;

    logic            i_valid4, i_rvld4, i_ready4;
    logic [127:0]    i_b4;
    logic [95:0]     i_n4;
    logic            o_ready4, o_rreq4, o_valid4;
    logic [127:0]    o_a4;

    int checks = 0;
    int errors = 0;

    sec_b2a_serial #(.K_WIDTH(32), .N_SHARES(3), .DIGIT(1)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_b     (i_b),
        .i_rvld  (i_rvld),
        .i_n     (i_n),
        .o_rreq  (o_rreq),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_a     (o_a)
    );

    sec_b2a_serial #(.K_WIDTH(32), .N_SHARES(4), .DIGIT(4)) dut4 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (i_valid4),
        .o_ready (o_ready4),
        .i_b     (i_b4),
        .i_rvld  (i_rvld4),
        .i_n     (i_n4),
        .o_rreq  (o_rreq4),
        .o_valid (o_valid4),
        .i_ready (i_ready4),
        .o_a     (o_a4)
    );

    function automatic logic [31:0] sum3(input logic [95:0] v);
        return v[31:0] + v[63:32] + v[95:64];
    endfunction

    function automatic logic [31:0] sum4(input logic [127:0] v);
        return v[31:0] + v[63:32] + v[95:64] + v[127:96];
    endfunction

    // Presents one job (accepted on the first edge) and waits for o_valid.
    // i_rvld is dropped for edges st_from .. st_from+st_len-1 counted from the accept edge.
    task automatic run_job(input logic [31:0] x, input logic [31:0] m1, input logic [31:0] m2,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input int st_from, input int st_len, output int lat);
        i_b     = {m2, m1, x ^ m1 ^ m2};
        i_n     = {a1, a0};
        i_valid = 1'b1;
        i_rvld  = 1'b1;
        @(posedge clk_i); #1;
        i_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            i_rvld = (n >= st_from && n < st_from + st_len) ? 1'b0 : 1'b1;
            i_n    = {$urandom, $urandom};
            @(posedge clk_i); #1;
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        i_rvld = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        i_valid = 1'b0; i_rvld = 1'b0; i_ready = 1'b0; i_b = '0; i_n = '0;
        i_valid4 = 1'b0; i_rvld4 = 1'b0; i_ready4 = 1'b0; i_b4 = '0; i_n4 = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        checks++; if (o_a !== 96'h0) begin errors++; $display("FAIL reset_o_a: got %h want 0", o_a); end
        checks++; if (o_rreq !== 1'b1) begin errors++; $display("FAIL reset_o_rreq: got %b want 1", o_rreq); end
    endtask

    task automatic test_rvld_gate();
        i_b = 96'h1; i_valid = 1'b1; i_rvld = 1'b0;
        @(posedge clk_i); #1;
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL no_accept_without_rvld: o_ready got %b want 1", o_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] x, a0, a1;
        int lat;
        x = 32'h12345678; a0 = 32'h0BADF00D; a1 = 32'h13579BDF;
        run_job(x, 32'hA5A5A5A5, 32'h0F0F0F0F, a0, a1, 0, 0, lat);
        checks++; if (lat != 67) begin errors++; $display("FAIL basic_latency: got %0d want 67", lat); end
        checks++; if (o_a[31:0] !== a0) begin errors++; $display("FAIL basic_share0: got %h want %h", o_a[31:0], a0); end
        checks++; if (o_a[63:32] !== a1) begin errors++; $display("FAIL basic_share1: got %h want %h", o_a[63:32], a1); end
        checks++; if (o_a[95:64] !== x - a0 - a1) begin errors++; $display("FAIL basic_share2: got %h want %h", o_a[95:64], x - a0 - a1); end
        checks++; if (sum3(o_a) !== x) begin errors++; $display("FAIL basic_sum: got %h want %h", sum3(o_a), x); end
        checks++; if (o_rreq !== 1'b0) begin errors++; $display("FAIL done_o_rreq: got %b want 0", o_rreq); end
        i_ready = 1'b1;
        @(posedge clk_i); #1;
        i_ready = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake: valid=%b ready=%b want 0/1", o_valid, o_ready); end
    endtask

    task automatic test_wrap();
        int lat;
        run_job(32'hFFFFFFFF, 32'h5A5A5A5A, 32'h3C3C3C3C, 32'h1, 32'h1, 0, 0, lat);
        checks++; if (lat != 67) begin errors++; $display("FAIL wrap_latency: got %0d want 67", lat); end
        checks++; if (o_a[95:64] !== 32'hFFFFFFFD) begin errors++; $display("FAIL wrap_share2: got %h want fffffffd", o_a[95:64]); end
        checks++; if (sum3(o_a) !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_sum: got %h want ffffffff", sum3(o_a)); end
        i_ready = 1'b1;
        @(posedge clk_i); #1;
        i_ready = 1'b0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL wrap_handshake: o_ready got %b want 1", o_ready); end
    endtask

    task automatic test_starve();
        logic [31:0] x, a0, a1;
        int lat;
        x = 32'h12345678; a0 = 32'h0BADF00D; a1 = 32'h13579BDF;
        run_job(x, 32'hA5A5A5A5, 32'h0F0F0F0F, a0, a1, 40, 10, lat);
        checks++; if (lat != 77) begin errors++; $display("FAIL starve_latency: got %0d want 77", lat); end
        checks++; if (o_a !== {x - a0 - a1, a1, a0}) begin errors++; $display("FAIL starve_result: got %h want %h", o_a, {x - a0 - a1, a1, a0}); end
        i_ready = 1'b1;
        @(posedge clk_i); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] x, a0, a1;
        logic [95:0] exp_a;
        int lat;
        x = 32'hCAFEF00D; a0 = 32'h01020304; a1 = 32'hA0B0C0D0;
        exp_a = {x - a0 - a1, a1, a0};
        run_job(x, 32'h77777777, 32'h12121212, a0, a1, 0, 0, lat);
        checks++; if (lat != 67) begin errors++; $display("FAIL bp_latency: got %0d want 67", lat); end
        i_b = 96'h123; i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            checks++; if (o_a !== exp_a) begin errors++; $display("FAIL bp_o_a_stable cycle %0d: got %h want %h", c, o_a, exp_a); end
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_o_valid cycle %0d: got %b want 1", c, o_valid); end
            checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_o_ready cycle %0d: got %b want 0", c, o_ready); end
        end
        i_ready = 1'b1;
        @(posedge clk_i); #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
        checks++; if (o_a !== exp_a) begin errors++; $display("FAIL bp_o_a_hold: got %h want %h", o_a, exp_a); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] x, a0, a1;
        int lat;
        i_b = {32'h11111111, 32'h22222222, 32'h33333333};
        i_n = {32'h44444444, 32'h55555555};
        i_valid = 1'b1; i_rvld = 1'b1;
        @(posedge clk_i); #1;
        i_valid = 1'b0;
        // 39 steps leave the DUT at p=1, d=7.
        repeat (39) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_o_valid: got %b want 0", o_valid); end
        checks++; if (o_a !== 96'h0) begin errors++; $display("FAIL mid_reset_o_a: got %h want 0", o_a); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_o_ready: got %b want 1", o_ready); end
        x = 32'hDEADBEEF; a0 = 32'h89ABCDEF; a1 = 32'h00FF00FF;
        run_job(x, 32'hF0F0F0F0, 32'h13371337, a0, a1, 0, 0, lat);
        checks++; if (lat != 67) begin errors++; $display("FAIL after_reset_latency: got %0d want 67", lat); end
        checks++; if (sum3(o_a) !== x) begin errors++; $display("FAIL after_reset_sum: got %h want %h", sum3(o_a), x); end
        checks++; if (o_a[95:64] !== x - a0 - a1) begin errors++; $display("FAIL after_reset_share2: got %h want %h", o_a[95:64], x - a0 - a1); end
        i_ready = 1'b1;
        @(posedge clk_i); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_param4(input logic [31:0] x);
        logic [31:0] m1, m2, m3;
        int lat;
        m1 = 32'h6B8B4567; m2 = 32'h327B23C6; m3 = 32'h643C9869;
        i_b4 = {m3, m2, m1, x ^ m1 ^ m2 ^ m3};
        i_n4 = '0;
        i_rvld4 = 1'b1; i_valid4 = 1'b1;
        @(posedge clk_i); #1;
        i_valid4 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_i); #1;
            if (o_valid4) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 27) begin errors++; $display("FAIL n4_latency x=%h: got %0d want 27", x, lat); end
        checks++; if (sum4(o_a4) !== x) begin errors++; $display("FAIL n4_sum x=%h: got %h want %h", x, sum4(o_a4), x); end
        checks++; if (o_a4[31:0] !== 32'h0) begin errors++; $display("FAIL n4_share0 x=%h: got %h want 0", x, o_a4[31:0]); end
        i_ready4 = 1'b1;
        @(posedge clk_i); #1;
        i_ready4 = 1'b0;
        checks++; if (o_ready4 !== 1'b1) begin errors++; $display("FAIL n4_handshake x=%h: o_ready got %b want 1", x, o_ready4); end
    endtask

    initial begin
        test_reset();
        test_rvld_gate();
        test_basic();
        test_wrap();
        test_starve();
        test_backpressure();
        test_reset_mid();
        test_param4(32'h80000000);
        test_param4(32'h00000000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
